// File: rtl/regfile_pkg.sv
// regfile_pkg: shared FSM encoding and default widths for regfile_mp
package regfile_pkg;
    localparam int DATA_W_DEF = 64;
    localparam int ADDR_W_DEF = 5;
    localparam int ZERO_REG_DEF = 31;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;
endpackage

// File: rtl/regfile_clr_fsm.sv
// regfile_clr_fsm: walks every entry once to zero it after reset or ClrReq
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_REGS = 2 ** ADDR_W
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              ClrReq,
    output logic              Busy,
    output logic              ClrDone,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
    logic [0:0] state;
    logic [ADDR_W-1:0] ptr;
    logic last;
    assign Busy = state == ST_CLEAR;
    assign last = ptr == LAST;
    assign clr_we = Busy;
    assign clr_addr = ptr;
    // ClrReq is only honoured from IDLE, so a running sweep is never restarted by it
    always_ff @(posedge Clk) begin
        state <= !Rst_n ? ST_CLEAR : Busy ? (last ? ST_IDLE : ST_CLEAR) : (ClrReq ? ST_CLEAR : ST_IDLE);
        ptr <= (!Rst_n || !Busy || last) ? '0 : ptr + 1'b1;
        ClrDone <= Rst_n && Busy && last;
    end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with hardwired zero entry and clear sequencer
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_REGS = 2 ** ADDR_W,
    parameter int NUM_RD = 2,
    parameter int ZERO_REG = ZERO_REG_DEF
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] RA,
    output logic [NUM_RD*DATA_W-1:0] Bus,
    input  logic [ADDR_W-1:0]        RW,
    input  logic [DATA_W-1:0]        BusW,
    input  logic                     RegWr,
    input  logic                     ClrReq,
    output logic                     Busy,
    output logic                     ClrDone
);
    localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);
    localparam logic [ADDR_W:0] NREGS = (ADDR_W + 1)'(NUM_REGS);
    logic [DATA_W-1:0] mem [NUM_REGS];
    logic clrWe;
    logic [ADDR_W-1:0] clrAddr;
    logic validW;
    logic wrOk;
    regfile_clr_fsm #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) uClr (
        .Clk(Clk),
        .Rst_n(Rst_n),
        .ClrReq(ClrReq),
        .Busy(Busy),
        .ClrDone(ClrDone),
        .clr_we(clrWe),
        .clr_addr(clrAddr)
    );
    assign validW = RW != ZR && {1'b0, RW} < NREGS;
    // a clear request in the same cycle as a write wins and drops the write
    assign wrOk = RegWr && !Busy && !ClrReq && Rst_n && validW;
    always_ff @(posedge Clk) begin
        if (clrWe) mem[clrAddr] <= '0;
        else if (wrOk) mem[RW] <= BusW;
    end
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic hit;
        assign ra = RA[i*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
        assign hit = RegWr && !Busy && validW && RW == ra;
`else
        assign hit = 1'b0;
`endif
        assign Bus[i*DATA_W +: DATA_W] = (Busy || ra == ZR || {1'b0, ra} >= NREGS) ? '0 : hit ? BusW : mem[ra];
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: random and directed checks of regfile_mp against a counter/array model
module tb_regfile_mp;
    logic Clk = 1'b0;
    logic Rst_n;
    logic [9:0] RA;
    logic [127:0] Bus;
    logic [4:0] RW;
    logic [63:0] BusW;
    logic RegWr;
    logic ClrReq;
    logic Busy;
    logic ClrDone;
    int checks = 0;
    int errors = 0;
    logic [63:0] m [32];
    int left = 0;
    logic mDone = 1'b0;
    logic mValid = 1'b0;
    logic busyS, doneS;
    int n, d;

    regfile_mp dut (
        .Clk(Clk), .Rst_n(Rst_n), .RA(RA), .Bus(Bus), .RW(RW), .BusW(BusW),
        .RegWr(RegWr), .ClrReq(ClrReq), .Busy(Busy), .ClrDone(ClrDone)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] expBus(input logic [4:0] ra);
        if (left > 0 || ra == 5'd31) return 64'h0;
`ifdef REGFILE_BYPASS_EN
        if (RegWr && RW == ra) return BusW;
`endif
        return m[ra];
    endfunction

    task automatic samp();
        #3;
        busyS = Busy;
        doneS = ClrDone;
        if (mValid) begin
            chk("busy", 64'(Busy), 64'(left > 0));
            chk("clrdone", 64'(ClrDone), 64'(mDone));
            chk("bus0", Bus[63:0], expBus(RA[4:0]));
            chk("bus1", Bus[127:64], expBus(RA[9:5]));
        end
    endtask

    // model: a busy countdown of 32 edges; entries zeroed whenever a clear starts
    task automatic adv();
        @(posedge Clk);
        if (!Rst_n) begin
            left = 32;
            mDone = 1'b0;
            mValid = 1'b1;
            foreach (m[k]) m[k] = '0;
        end else begin
            mDone = left == 1;
            if (left > 0) left--;
            else if (ClrReq) begin
                left = 32;
                foreach (m[k]) m[k] = '0;
            end else if (RegWr && RW != 5'd31) m[RW] = BusW;
        end
        #1;
    endtask

    task automatic measure(input int clrAt, input int rstAt, output int nb, output int nd);
        nb = 0;
        nd = 0;
        for (int k = 0; k < 100; k++) begin
            ClrReq = k == clrAt;
            Rst_n = !(k == rstAt);
            samp();
            if (busyS) nb++;
            if (doneS) nd++;
            if (k == rstAt) nb = 0;
            adv();
            if (!busyS) break;
        end
        ClrReq = 1'b0;
        Rst_n = 1'b1;
        samp();
        if (doneS) nd++;
        adv();
    endtask

    initial begin
        Rst_n = 1'b0; RA = '0; RW = '0; BusW = '0; RegWr = 1'b0; ClrReq = 1'b0;
        #1;
        repeat (3) begin samp(); adv(); end
        samp();
        chk("rst_busy", 64'(Busy), 64'd1);
        chk("rst_done", 64'(ClrDone), 64'd0);
        chk("rst_bus", Bus[63:0], 64'd0);
        adv();
        Rst_n = 1'b1;
        measure(-1, -1, n, d);
        chk("init_busy_len", 64'(n), 64'd32);
        chk("init_done_cnt", 64'(d), 64'd1);
        RegWr = 1'b1; RW = 5'd31; BusW = 64'h12345678;
        samp(); adv();
        RegWr = 1'b0; RA = {5'd31, 5'd31};
        samp();
        chk("zr_p0", Bus[63:0], 64'd0);
        chk("zr_p1", Bus[127:64], 64'd0);
        adv();
        RegWr = 1'b1; RW = 5'd13; BusW = 64'hABCD;
        samp(); adv();
        RegWr = 1'b0; RA = {5'd0, 5'd13};
        samp();
        chk("r13", Bus[63:0], 64'hABCD);
        adv();
        for (int r = 0; r < 31; r++) begin
            RegWr = 1'b1; RW = 5'(r); BusW = 64'(r);
            samp(); adv();
        end
        RegWr = 1'b0; RA = {5'd3, 5'd2};
        samp();
        chk("pair_2", Bus[63:0], 64'd2);
        chk("pair_3", Bus[127:64], 64'd3);
        adv();
        RA = {5'd11, 5'd10}; RW = 5'd20; BusW = 64'hDEAD;
        samp();
        chk("pair_10", Bus[63:0], 64'd10);
        chk("pair_11", Bus[127:64], 64'd11);
        adv();
        samp();
        chk("reread_10", Bus[63:0], 64'd10);
        adv();
        RegWr = 1'b1; RW = 5'd5; BusW = 64'h55; ClrReq = 1'b1;
        samp(); adv();
        RegWr = 1'b0;
        measure(10, -1, n, d);
        chk("clr_busy_len", 64'(n), 64'd32);
        chk("clr_done_cnt", 64'(d), 64'd1);
        RA = {5'd0, 5'd5};
        samp();
        chk("r5_dropped", Bus[63:0], 64'd0);
        adv();
        ClrReq = 1'b1;
        samp(); adv();
        measure(-1, 10, n, d);
        chk("rst_mid_len", 64'(n), 64'd32);
        chk("rst_mid_done", 64'(d), 64'd1);
        RegWr = 1'b1; RW = 5'd7; BusW = 64'h1;
        samp(); adv();
        BusW = 64'h77; RA = {5'd0, 5'd7};
        samp();
`ifdef REGFILE_BYPASS_EN
        chk("bypass_r7", Bus[63:0], 64'h77);
`else
        chk("nobypass_r7", Bus[63:0], 64'h1);
`endif
        adv();
        RegWr = 1'b0;
        samp();
        chk("after_r7", Bus[63:0], 64'h77);
        adv();
        for (int c = 0; c < 800; c++) begin
            Rst_n = $urandom_range(0, 299) != 0;
            ClrReq = $urandom_range(0, 199) == 0;
            RegWr = $urandom_range(0, 3) != 0;
            RW = 5'($urandom_range(0, 31));
            BusW = {$urandom, $urandom};
            RA[4:0] = $urandom_range(0, 3) == 0 ? RW : 5'($urandom_range(0, 31));
            RA[9:5] = 5'($urandom_range(0, 31));
            samp(); adv();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file: the next generation of the datapath's 32×64 register file. Width, depth, read-port count and the hardwired-zero register index are configurable. A built-in clear sequencer zeroes every entry after reset or on request, and stalls writes while it runs. It sits between decode (read addresses) and writeback (write port) in the single-cycle/pipelined CPU datapath.

## Interface
Parameters:
- DATA_W, 64, register width in bits
- ADDR_W, 5, address width
- NUM_REGS, 2**ADDR_W, number of entries (≤ 2**ADDR_W)
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 31, index that always reads 0 and ignores writes

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Rst_n  in  1  reset, synchronous, active-low
- RA  in  NUM_RD*ADDR_W  read addresses; port i uses bits [i*ADDR_W +: ADDR_W]
- Bus  out  NUM_RD*DATA_W  read data; port i uses bits [i*DATA_W +: DATA_W]
- RW  in  ADDR_W  write address
- BusW  in  DATA_W  write data
- RegWr  in  1  write enable
- ClrReq  in  1  single-cycle request to zero all entries
- Busy  out  1  clear sequence in progress; writes are dropped
- ClrDone  out  1  one-cycle pulse when a clear sequence finishes

## Operation
- Reads are combinational. Bus[i] = mem[RA[i]].
- Bus[i] = 0 when RA[i]==ZERO_REG, when RA[i] ≥ NUM_REGS, or when Busy=1.
- Write: on a rising edge with RegWr=1, Busy=0, RW≠ZERO_REG and RW<NUM_REGS, mem[RW] ← BusW. All other write attempts are silently dropped.
- Clear sequencer FSM, states IDLE and CLEAR, with pointer Ptr (ADDR_W bits):
  - Rst_n=0 → CLEAR, Ptr=0.
  - In CLEAR, each cycle: mem[Ptr] ← 0, Ptr++. When Ptr==NUM_REGS-1, the next state is IDLE and ClrDone=1 on that transition.
  - In IDLE: ClrReq=1 → CLEAR, Ptr=0.
  - ClrReq while in CLEAR is ignored; the sequence does not restart.
- Simultaneous ClrReq and RegWr in IDLE: the clear wins and the write is dropped.
- Reset during CLEAR restarts the sequence at Ptr=0.
- Arithmetic: Ptr compares against NUM_REGS-1 at full ADDR_W width. No wrap is ever taken.

## Timing
- Reset values: Busy=1, ClrDone=0, Ptr=0, state=CLEAR. Bus=0, because Busy=1.
- After Rst_n rises, Busy stays high for exactly NUM_REGS cycles.
- ClrDone pulses for one cycle, coincident with Busy falling.
- ClrReq sampled at edge k: Busy=1 from edge k through edge k+NUM_REGS.
- Write latency: data written at edge k is visible on Bus after edge k, i.e. read-after-write needs 1 cycle. The exception is the bypass configuration below.
- Read latency: 0 cycles (combinational from RA).

## Configuration
- REGFILE_BYPASS_EN defined: write-to-read forwarding.
  - If RegWr=1, Busy=0, RW==RA[i], RW≠ZERO_REG and RW<NUM_REGS, then Bus[i]=BusW in the same cycle.
  - This gives the pipeline same-cycle writeback/decode forwarding.
- Undefined: no forwarding. Bus[i] shows the old contents until the edge.

## Structure
- Package regfile_pkg holds:
  - the FSM state encoding (ST_IDLE, ST_CLEAR)
  - default width constants (DATA_W_DEF=64, ADDR_W_DEF=5, ZERO_REG_DEF=31)
- Sub-module regfile_clr_fsm:
  - contains the state register, Ptr, Busy and ClrDone
  - outputs clr_we and clr_addr to the array write mux
- The top level holds the storage array, the write arbitration (clear over RegWr) and the NUM_RD read muxes (generate loop).

## Test plan
- Reset with defaults → Busy=1 for 32 cycles after Rst_n rises, ClrDone pulses once, all Bus reads 0 throughout.
- Write 64'h12345678 to reg 31, then read reg 31 on both ports → Bus=0. Write 64'hABCD to reg 13, read it next cycle → 64'hABCD.
- Fill regs 0..30 with value=index, read pairs (2,3), (10,11) → 2,3 / 10,11. Re-read with RegWr=0 and differing RW → values unchanged.
- ClrReq and RegWr (reg 5 ← 64'h55) in the same cycle → write dropped, Busy 32 cycles, reg 5 reads 0 afterwards. ClrReq mid-clear → still exactly 32 cycles.
- Rst_n pulsed low at Ptr=10 mid-clear → sequence restarts, Busy lasts 32 cycles from release.
- With REGFILE_BYPASS_EN: RegWr=1, RW=7, BusW=64'h77, RA0=7 → Bus0=64'h77 in the same cycle. Without the macro → old value until the edge.
